// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display types and constants.
// Used by the sprite draw engine and its row merge datapath.
package chip8_pkg;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_FETCH,
        DS_RDDISP,
        DS_WRITE,
        DS_DONE
    } draw_state_t;

    localparam int LORES_W         = 64;
    localparam int LORES_H         = 32;
    localparam int HIRES_W         = 128;
    localparam int HIRES_H         = 64;
    localparam int SPRITE_ROWS_MAX = 15;

    // Spread one sprite byte across the two display bytes it can touch.
    function automatic logic [15:0] spr_shift(
        input logic [7:0] s,
        input logic [2:0] sh
    );
        return {s, 8'h00} >> sh;
    endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Bus bundle between the sprite draw engine, its requester,
// the sprite memory and the dual-port display RAM.
interface sprite_draw_engine_if #(
    parameter int MEM_AW  = 12,
    parameter int DISP_AW = 8
);
    logic               start;
    logic [7:0]         x;
    logic [7:0]         y;
    logic [3:0]         n;
    logic [MEM_AW-1:0]  i_addr;
    logic               clip;
    logic               busy;
    logic               done;
    logic               collision;
    logic               ram_req;
    logic [MEM_AW-1:0]  mem_a;
    logic [7:0]         mem_q;
    logic [DISP_AW-1:0] disp_aa;
    logic [DISP_AW-1:0] disp_ab;
    logic [7:0]         disp_da;
    logic [7:0]         disp_db;
    logic               disp_wa;
    logic               disp_wb;
    logic [7:0]         disp_qa;
    logic [7:0]         disp_qb;

    modport master (
        output start, x, y, n, i_addr, clip,
        output mem_q, disp_qa, disp_qb,
        input  busy, done, collision, ram_req,
        input  mem_a, disp_aa, disp_ab,
        input  disp_da, disp_db, disp_wa, disp_wb
    );

    modport slave (
        input  start, x, y, n, i_addr, clip,
        input  mem_q, disp_qa, disp_qb,
        output busy, done, collision, ram_req,
        output mem_a, disp_aa, disp_ab,
        output disp_da, disp_db, disp_wa, disp_wb
    );

endinterface

// File: rtl/sprite_row_merge.sv
// Combinational row merge: shift a sprite byte, XOR into the two
// display bytes, and derive collision and the right-byte enable.
module sprite_row_merge
    import chip8_pkg::*;
(
    input  logic [7:0] spr_i,
    input  logic [2:0] sh_i,
    input  logic [7:0] qa_i,
    input  logic [7:0] qb_i,
    input  logic       clip_i,
    input  logic       last_col_i,
    output logic [7:0] da_o,
    output logic [7:0] db_o,
    output logic       wb_en_o,
    output logic       hit_o
);

    logic [15:0] s;

    assign s = spr_shift(spr_i, sh_i);

    // Aligned sprites never spill; clipped ones must not wrap to column 0.
    assign wb_en_o = (sh_i != 3'd0) && !(clip_i && last_col_i);

    assign da_o  = qa_i ^ s[15:8];
    assign db_o  = qb_i ^ s[7:0];
    assign hit_o = (|(qa_i & s[15:8]))
                 | (wb_en_o & (|(qb_i & s[7:0])));

endmodule

// File: rtl/sprite_draw_engine.sv
// CHIP-8 DXYN sprite draw: fetch rows, read-modify-write the packed
// 1bpp display RAM through two byte ports, accumulate VF collision.
module sprite_draw_engine
    import chip8_pkg::*;
#(
    parameter int DISP_W  = 64,
    parameter int DISP_H  = 32,
    parameter int MEM_AW  = 12,
    parameter int DISP_AW = $clog2(DISP_W * DISP_H / 8)
) (
    input  logic clk,
    input  logic reset,
    input  logic may_run,
    sprite_draw_engine_if.slave bus
);

    localparam int CPR = DISP_W / 8;
    localparam int XW  = $clog2(DISP_W);
    localparam int YW  = $clog2(DISP_H);
    localparam int CW  = XW - 3;
    localparam int YSW = YW + 5;

    localparam logic [2:0] S_IDLE   = DS_IDLE;
    localparam logic [2:0] S_FETCH  = DS_FETCH;
    localparam logic [2:0] S_RDDISP = DS_RDDISP;
    localparam logic [2:0] S_WRITE  = DS_WRITE;
    localparam logic [2:0] S_DONE   = DS_DONE;

    logic [2:0]        st_q, st_d;
    logic [XW-1:0]     x0_q, x0_d;
    logic [YW-1:0]     y0_q, y0_d;
    logic [3:0]        n_q, n_d;
    logic [MEM_AW-1:0] ia_q, ia_d;
    logic              clip_q, clip_d;
    logic [3:0]        r_q, r_d;
    logic [YW-1:0]     row_q, row_d;
    logic [7:0]        spr_q, spr_d;
    logic              coll_q, coll_d;

    logic [YSW-1:0]     yr;
    logic [CW-1:0]      c0, c1;
    logic               last_col;
    logic [DISP_AW-1:0] rowbase;
    logic               addr_en;
    logic               is_wr;
    logic [7:0]         da_m, db_m;
    logic               wb_en;
    logic               hit;

    assign yr       = YSW'(y0_q) + YSW'(r_q);
    assign c0       = x0_q[XW-1:3];
    assign last_col = (c0 == CW'(CPR - 1));
    assign c1       = last_col ? '0 : c0 + CW'(1);
    assign rowbase  = DISP_AW'(row_q) * DISP_AW'(CPR);
    assign addr_en  = (st_q == S_RDDISP) || (st_q == S_WRITE);
    assign is_wr    = (st_q == S_WRITE);

    sprite_row_merge u_merge (
        .spr_i      (spr_q),
        .sh_i       (x0_q[2:0]),
        .qa_i       (bus.disp_qa),
        .qb_i       (bus.disp_qb),
        .clip_i     (clip_q),
        .last_col_i (last_col),
        .da_o       (da_m),
        .db_o       (db_m),
        .wb_en_o    (wb_en),
        .hit_o      (hit)
    );

    assign bus.busy      = (st_q == S_FETCH) || addr_en;
    assign bus.ram_req   = bus.busy;
    assign bus.done      = (st_q == S_DONE);
    assign bus.collision = coll_q;
    assign bus.mem_a     = ia_q + MEM_AW'(r_q);
    assign bus.disp_aa   = addr_en ? rowbase + DISP_AW'(c0) : '0;
    assign bus.disp_ab   = addr_en ? rowbase + DISP_AW'(c1) : '0;
    assign bus.disp_da   = is_wr ? da_m : 8'h00;
    assign bus.disp_db   = is_wr ? db_m : 8'h00;
    assign bus.disp_wa   = is_wr && may_run;
    assign bus.disp_wb   = is_wr && may_run && wb_en;

    always_comb begin
        st_d   = st_q;
        x0_d   = x0_q;
        y0_d   = y0_q;
        n_d    = n_q;
        ia_d   = ia_q;
        clip_d = clip_q;
        r_d    = r_q;
        row_d  = row_q;
        spr_d  = spr_q;
        coll_d = coll_q;
        // Holding may_run low freezes every register, WRITE included.
        if (may_run) begin
            unique case (st_q)
                S_IDLE: begin
                    if (bus.start) begin
                        x0_d   = XW'({8'd0, bus.x} % 16'(DISP_W));
                        y0_d   = YW'({8'd0, bus.y} % 16'(DISP_H));
                        n_d    = bus.n;
                        ia_d   = bus.i_addr;
                        clip_d = bus.clip;
                        coll_d = 1'b0;
                        r_d    = 4'd0;
                        st_d   = (bus.n == 4'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (clip_q && yr >= YSW'(DISP_H)) begin
                        st_d = S_DONE;
                    end else begin
                        row_d = YW'(yr % YSW'(DISP_H));
                        st_d  = S_RDDISP;
                    end
                end
                S_RDDISP: begin
                    spr_d = bus.mem_q;
                    st_d  = S_WRITE;
                end
                S_WRITE: begin
                    coll_d = coll_q | hit;
                    r_d    = r_q + 4'd1;
                    st_d   = (r_q + 4'd1 == n_q) ? S_DONE : S_FETCH;
                end
                S_DONE: st_d = S_IDLE;
                default: st_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= S_IDLE;
            x0_q   <= '0;
            y0_q   <= '0;
            n_q    <= '0;
            ia_q   <= '0;
            clip_q <= 1'b0;
            r_q    <= '0;
            row_q  <= '0;
            spr_q  <= '0;
            coll_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            x0_q   <= x0_d;
            y0_q   <= y0_d;
            n_q    <= n_d;
            ia_q   <= ia_d;
            clip_q <= clip_d;
            r_q    <= r_d;
            row_q  <= row_d;
            spr_q  <= spr_d;
            coll_q <= coll_d;
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: a 64x32 and a 128x64
// instance sharing one sprite memory, each with its own display RAM.
module tb_sprite_draw_engine;

    logic clk = 1'b0;
    logic rst_lo, rst_hi, run_lo, run_hi, clr;
    int   checks = 0;
    int   errors = 0;
    int   wa_lo = 0;
    int   wb_lo = 0;
    int   w_hi = 0;
    int   cyc;
    int   w0;

    logic [7:0] mem [4096];
    logic [7:0] dlo [256];
    logic [7:0] dhi [1024];

    always #5 clk = ~clk;

    sprite_draw_engine_if #(.MEM_AW(12), .DISP_AW(8))  lo ();
    sprite_draw_engine_if #(.MEM_AW(12), .DISP_AW(10)) hi ();

    sprite_draw_engine #(.DISP_W(64), .DISP_H(32), .MEM_AW(12)) u_lo (
        .clk     (clk),
        .reset   (rst_lo),
        .may_run (run_lo),
        .bus     (lo.slave)
    );

    sprite_draw_engine #(.DISP_W(128), .DISP_H(64), .MEM_AW(12)) u_hi (
        .clk     (clk),
        .reset   (rst_hi),
        .may_run (run_hi),
        .bus     (hi.slave)
    );

    always @(posedge clk) begin
        lo.mem_q   <= mem[lo.mem_a];
        lo.disp_qa <= dlo[lo.disp_aa];
        lo.disp_qb <= dlo[lo.disp_ab];
        if (clr) begin
            for (int k = 0; k < 256; k++) dlo[k] <= 8'h00;
        end else begin
            if (lo.disp_wa) begin
                dlo[lo.disp_aa] <= lo.disp_da;
                wa_lo <= wa_lo + 1;
            end
            if (lo.disp_wb) begin
                dlo[lo.disp_ab] <= lo.disp_db;
                wb_lo <= wb_lo + 1;
            end
        end
    end

    always @(posedge clk) begin
        hi.mem_q   <= mem[hi.mem_a];
        hi.disp_qa <= dhi[hi.disp_aa];
        hi.disp_qb <= dhi[hi.disp_ab];
        if (clr) begin
            for (int k = 0; k < 1024; k++) dhi[k] <= 8'h00;
        end else begin
            if (hi.disp_wa && hi.disp_wb) begin
                dhi[hi.disp_aa] <= hi.disp_da;
                dhi[hi.disp_ab] <= hi.disp_db;
                w_hi <= w_hi + 2;
            end else if (hi.disp_wa) begin
                dhi[hi.disp_aa] <= hi.disp_da;
                w_hi <= w_hi + 1;
            end else if (hi.disp_wb) begin
                dhi[hi.disp_ab] <= hi.disp_db;
                w_hi <= w_hi + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ram;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic draw_lo(input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] n, input logic [11:0] ia,
                           input logic cl, output int c);
        lo.x      = x;
        lo.y      = y;
        lo.n      = n;
        lo.i_addr = ia;
        lo.clip   = cl;
        lo.start  = 1'b1;
        tick();
        lo.start  = 1'b0;
        c = 1;
        while (!lo.done && c < 100) begin
            tick();
            c++;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'h100] = 8'hFF;
        mem[12'h200] = 8'h81; mem[12'h201] = 8'h42;
        mem[12'h202] = 8'h24; mem[12'h203] = 8'h18;
        for (int k = 0; k < 4; k++) mem[12'h300 + k] = 8'hFF;

        rst_lo = 1'b1; rst_hi = 1'b1;
        run_lo = 1'b1; run_hi = 1'b1;
        clr = 1'b1;
        lo.start = 1'b0; lo.x = 8'd0; lo.y = 8'd0; lo.n = 4'd0;
        lo.i_addr = 12'd0; lo.clip = 1'b0;
        hi.start = 1'b0; hi.x = 8'd0; hi.y = 8'd0; hi.n = 4'd0;
        hi.i_addr = 12'd0; hi.clip = 1'b0;
        tick(); tick();
        clr = 1'b0;

        chk("rst_busy", {31'd0, lo.busy}, 32'd0);
        chk("rst_done", {31'd0, lo.done}, 32'd0);
        chk("rst_coll", {31'd0, lo.collision}, 32'd0);
        chk("rst_req", {31'd0, lo.ram_req}, 32'd0);
        chk("rst_we", {30'd0, lo.disp_wa, lo.disp_wb}, 32'd0);
        chk("rst_addr", {lo.mem_a, lo.disp_aa, lo.disp_ab}, 32'd0);
        chk("rst_data", {16'd0, lo.disp_da, lo.disp_db}, 32'd0);

        rst_lo = 1'b0;
        tick();

        draw_lo(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, cyc);
        chk("g0_cycles", cyc, 32'd16);
        chk("g0_b0", dlo[0], 32'hF0);
        chk("g0_b8", dlo[8], 32'h90);
        chk("g0_b16", dlo[16], 32'h90);
        chk("g0_b24", dlo[24], 32'h90);
        chk("g0_b32", dlo[32], 32'hF0);
        chk("g0_wa", wa_lo, 32'd5);
        chk("g0_wb", wb_lo, 32'd0);
        chk("g0_coll", {31'd0, lo.collision}, 32'd0);
        chk("g0_idle", {31'd0, lo.busy}, 32'd0);

        draw_lo(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, cyc);
        chk("g1_cycles", cyc, 32'd16);
        chk("g1_b0", dlo[0], 32'h00);
        chk("g1_b16", dlo[16], 32'h00);
        chk("g1_b32", dlo[32], 32'h00);
        chk("g1_coll", {31'd0, lo.collision}, 32'd1);

        draw_lo(8'd0, 8'd0, 4'd0, 12'h050, 1'b0, cyc);
        chk("n0_cycles", cyc, 32'd1);
        chk("n0_coll", {31'd0, lo.collision}, 32'd0);
        chk("n0_wa", wa_lo, 32'd10);

        clear_ram();
        draw_lo(8'd62, 8'd0, 4'd1, 12'h100, 1'b0, cyc);
        chk("wrapx_cycles", cyc, 32'd4);
        chk("wrapx_b7", dlo[7], 32'h03);
        chk("wrapx_b0", dlo[0], 32'hFC);
        chk("wrapx_wb", wb_lo, 32'd1);

        clear_ram();
        w0 = wb_lo;
        draw_lo(8'd62, 8'd0, 4'd1, 12'h100, 1'b1, cyc);
        chk("clipx_b7", dlo[7], 32'h03);
        chk("clipx_b0", dlo[0], 32'h00);
        chk("clipx_wb", wb_lo - w0, 32'd0);

        clear_ram();
        w0 = wa_lo;
        draw_lo(8'd0, 8'd30, 4'd4, 12'h200, 1'b1, cyc);
        chk("clipy_cycles", cyc, 32'd8);
        chk("clipy_b240", dlo[240], 32'h81);
        chk("clipy_b248", dlo[248], 32'h42);
        chk("clipy_b0", dlo[0], 32'h00);
        chk("clipy_b8", dlo[8], 32'h00);
        chk("clipy_wa", wa_lo - w0, 32'd2);

        clear_ram();
        draw_lo(8'd0, 8'd30, 4'd4, 12'h200, 1'b0, cyc);
        chk("wrapy_cycles", cyc, 32'd13);
        chk("wrapy_b240", dlo[240], 32'h81);
        chk("wrapy_b248", dlo[248], 32'h42);
        chk("wrapy_b0", dlo[0], 32'h24);
        chk("wrapy_b8", dlo[8], 32'h18);

        rst_hi = 1'b0;
        tick();
        hi.x = 8'd130; hi.y = 8'd70; hi.n = 4'd4;
        hi.i_addr = 12'h300; hi.clip = 1'b0;
        hi.start = 1'b1;
        tick();
        hi.start = 1'b0;
        chk("hi_busy", {30'd0, hi.busy, hi.ram_req}, 32'd3);
        chk("hi_mem_a", hi.mem_a, 32'h300);
        tick();
        chk("hi_aa", hi.disp_aa, 32'd96);
        chk("hi_ab", hi.disp_ab, 32'd97);
        tick();
        run_hi = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_we", {30'd0, hi.disp_wa, hi.disp_wb}, 32'd0);
            tick();
        end
        chk("hold_b96", dhi[96], 32'h00);
        chk("hold_w", w_hi, 32'd0);
        chk("hold_busy", {31'd0, hi.busy}, 32'd1);
        run_hi = 1'b1;
        tick();
        chk("res_b96", dhi[96], 32'h3F);
        chk("res_b97", dhi[97], 32'hC0);
        chk("res_w", w_hi, 32'd2);
        tick(); tick(); tick();
        chk("r1_b112", dhi[112], 32'h3F);
        chk("r1_b113", dhi[113], 32'hC0);
        rst_hi = 1'b1;
        #1;
        chk("mrst_busy", {31'd0, hi.busy}, 32'd0);
        chk("mrst_we", {30'd0, hi.disp_wa, hi.disp_wb}, 32'd0);
        tick(); tick();
        rst_hi = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("mrst_b128", dhi[128], 32'h00);
        chk("mrst_b145", dhi[145], 32'h00);
        chk("mrst_w", w_hi, 32'd4);
        chk("mrst_idle", {30'd0, hi.busy, hi.done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
